u_ifu_fq: RTL and testbench
===========================

U_IFU_FQ -- requirements
Module: u_ifu_fq

Interface
REQ-001 SHALL have parameter FQ_DEPTH, default 4, fetch-queue entries; power of two, >=2.
REQ-002 SHALL have parameter RST_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port flush, input, 1, discard queue and in-flight fetch.
REQ-006 SHALL have port stall, input, 1, consumer not ready; no pop while high.
REQ-007 SHALL have port branch, input, 1, redirect fetch to br_adr.
REQ-008 SHALL have port br_adr, input, 32, redirect target.
REQ-009 SHALL have port ifu_vld, output, 1, queue head valid.
REQ-010 SHALL have port ifu_pc, output, 32, PC of queue head.
REQ-011 SHALL have port ifu_ins, output, 32, instruction of queue head.
REQ-012 SHALL have port ins_a, output, 32, instruction SRAM address.
REQ-013 SHALL have port ins_e, output, 1, instruction SRAM read enable.
REQ-014 SHALL have port ins, input, 32, SRAM read data, valid the cycle after ins_e=1.

Function
REQ-015 SHALL hold fetch PC register pc; ins_a = pc combinationally.
REQ-016 SHALL define pop = ifu_vld & !stall & !flush & !branch; pop removes the head at the clock edge.
REQ-017 SHALL define issue = ins_e = !branch & !flush & (count + infl - pop < FQ_DEPTH); count = queue occupancy, infl = 1 if a read was issued last cycle and not killed.
REQ-018 SHALL, on issue, set infl=1, record infl_pc=pc, and advance pc to pc+4 (32-bit wrap, 0xFFFF_FFFC+4 = 0).
REQ-019 SHALL, when infl=1 and not killed, write {infl_pc, ins} into the queue tail at that edge; entry visible on ifu_vld/ifu_pc/ifu_ins the next cycle.
REQ-020 SHALL give minimum latency issue->ifu_vld of 2 cycles and sustain 1 instruction/cycle with stall=0.
REQ-021 SHALL never overflow: the credit rule in REQ-017 guarantees a free slot for every in-flight return.
REQ-022 SHALL, on branch=1, set pc={br_adr[31:2],2'b00}, empty the queue, clear infl (drop the returning ins), and deassert ins_e that cycle.
REQ-023 SHALL, on flush=1 without branch, empty the queue, clear infl, and rewind pc to infl_pc if infl=1, else hold pc, so no instruction is lost.
REQ-024 SHALL, when branch and flush are both 1, apply REQ-022 (branch wins for pc).
REQ-025 SHALL leave queue, pc and infl unchanged when stall=1 and queue full, with ins_e=0.
REQ-026 SHALL drive ifu_pc/ifu_ins to 0 when ifu_vld=0.
REQ-027 SHALL allow simultaneous push and pop when count=FQ_DEPTH-1 or count=FQ_DEPTH; count changes by push-pop.

Reset
REQ-028 SHALL, while rst=1, force pc=RST_PC, count=0, infl=0, pointers=0, ifu_vld=0, ifu_pc=0, ifu_ins=0, ins_e=0.
REQ-029 SHALL, on rst asserting mid-operation, discard all entries and the in-flight read immediately (asynchronous).
REQ-030 SHALL issue the first read (ins_a=RST_PC, ins_e=1) in the first cycle after rst deasserts.

Structure
REQ-031 SHALL place XLEN=32, RST_PC default and typedef fq_entry_t {pc[31:0], ins[31:0]} in shared package u_ifu_pkg.
REQ-032 SHALL instantiate one sub-module u_fifo_sync (parametrised depth, fq_entry_t payload, push/pop/clear, count output).
REQ-033 SHALL keep all outputs of queue-head registers free of combinational paths from ins.

Verification
REQ-034 SHALL check reset release, stall=0, SRAM holds ins=addr^32'hA5A5_0000: ifu_vld rises cycle 2, ifu_pc=0,4,8,C on consecutive cycles.
REQ-035 SHALL check stall=1 for 10 cycles, FQ_DEPTH=4: exactly 4 entries queued, ins_e low thereafter, on release PCs continue contiguous with no duplicate or gap.
REQ-036 SHALL check branch=1, br_adr=32'h0000_0102 while queue holds 3 entries: next ifu_vld entry has ifu_pc=0x100, stale entries and in-flight 0x10 never appear.
REQ-037 SHALL check flush=1 with infl_pc=0x20: queue empties, next issued ins_a=0x20, ifu_pc sequence resumes 0x20,0x24.
REQ-038 SHALL check branch and flush same cycle to br_adr=0x40: ifu_pc resumes at 0x40; pc=0xFFFF_FFF8 wraps to 0xFFFF_FFFC then 0.
REQ-039 SHALL check rst pulse mid-stream with queue full: ifu_vld=0 immediately, restart at RST_PC.

Source files
------------

// File: rtl/u_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit fetch queue.
package u_ifu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RST_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ins;
  } fq_entry_t;
endpackage

// File: rtl/u_fifo_sync.sv
// Synchronous FIFO of fetch-queue entries with clear and occupancy count.
module u_fifo_sync
  import u_ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  fq_entry_t                din,
  output fq_entry_t                dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fq_entry_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;
endmodule

// File: rtl/u_ifu_fq.sv
// Fetch unit: sequential PC generation, SRAM read issue and credit-based fetch queue.
module u_ifu_fq
  import u_ifu_pkg::*;
#(
  parameter int              FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RST_PC   = RST_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            stall,
  input  logic            branch,
  input  logic [XLEN-1:0] br_adr,
  output logic            ifu_vld,
  output logic [XLEN-1:0] ifu_pc,
  output logic [XLEN-1:0] ifu_ins,
  output logic [XLEN-1:0] ins_a,
  output logic            ins_e,
  input  logic [XLEN-1:0] ins
);
  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] infl_pc_reg;
  logic            infl_reg;
  logic [CW-1:0]   count;
  logic [CW:0]     credit;
  logic            kill;
  logic            pop;
  logic            push;
  logic            issue;
  fq_entry_t       head;
  fq_entry_t       tail;
  logic            br_lsb_unused;

  assign br_lsb_unused = ^br_adr[1:0];

  assign kill    = branch | flush;
  assign ifu_vld = (count != '0);
  assign pop     = ifu_vld & ~stall & ~kill;
  assign push    = infl_reg & ~kill;

  // Slots already promised (queued plus returning) must leave room for this read.
  assign credit  = {1'b0, count} + (CW+1)'(infl_reg) - (CW+1)'(pop);
  assign issue   = ~kill & ~rst & (credit < (CW+1)'(FQ_DEPTH));
  assign ins_e   = issue;
  assign ins_a   = pc_reg;

  always_comb begin
    pc_next = pc_reg;
    if (branch) begin
      pc_next = {br_adr[XLEN-1:2], 2'b00};
    end else if (flush) begin
      // Rewind so the killed in-flight fetch is re-issued.
      if (infl_reg) pc_next = infl_pc_reg;
    end else if (issue) begin
      pc_next = pc_reg + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg      <= RST_PC;
      infl_reg    <= 1'b0;
      infl_pc_reg <= '0;
    end else begin
      pc_reg   <= pc_next;
      infl_reg <= issue;
      if (issue) infl_pc_reg <= pc_reg;
    end
  end

  assign tail = '{pc: infl_pc_reg, ins: ins};

  u_fifo_sync #(
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk   (clk),
    .rst   (rst),
    .clear (kill),
    .push  (push),
    .pop   (pop),
    .din   (tail),
    .dout  (head),
    .count (count)
  );

  assign ifu_pc  = ifu_vld ? head.pc  : '0;
  assign ifu_ins = ifu_vld ? head.ins : '0;
endmodule

// File: tb/tb_u_ifu_fq.sv
// Directed bench for u_ifu_fq: streaming, stall, branch, flush, wrap and reset.
module tb_u_ifu_fq;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        stall;
  logic        branch;
  logic [31:0] br_adr;
  logic        ifu_vld;
  logic [31:0] ifu_pc;
  logic [31:0] ifu_ins;
  logic [31:0] ins_a;
  logic        ins_e;
  logic [31:0] ins;

  int checks = 0;
  int errors = 0;

  u_ifu_fq #(.FQ_DEPTH(4), .RST_PC(32'h0000_0000)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .stall   (stall),
    .branch  (branch),
    .br_adr  (br_adr),
    .ifu_vld (ifu_vld),
    .ifu_pc  (ifu_pc),
    .ifu_ins (ifu_ins),
    .ins_a   (ins_a),
    .ins_e   (ins_e),
    .ins     (ins)
  );

  always #5 clk = ~clk;

  // SRAM model: data for an enabled address returns the following cycle.
  always @(posedge clk) begin
    if (ins_e) ins <= ins_a ^ 32'hA5A5_0000;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-12s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic head(input string tag, input logic [31:0] p);
    chk({tag, "_vld"}, {31'd0, ifu_vld}, 32'd1);
    chk({tag, "_pc"},  ifu_pc, p);
    chk({tag, "_ins"}, ifu_ins, p ^ 32'hA5A5_0000);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0; branch = 1'b0; br_adr = '0;

    // Reset state and first fetch
    tick(); tick();
    chk("rst_vld",  {31'd0, ifu_vld}, 32'd0);
    chk("rst_pc",   ifu_pc, 32'd0);
    chk("rst_ins",  ifu_ins, 32'd0);
    chk("rst_inse", {31'd0, ins_e}, 32'd0);
    chk("rst_insa", ins_a, 32'd0);
    rst = 1'b0; #1;
    chk("c0_inse", {31'd0, ins_e}, 32'd1);
    chk("c0_insa", ins_a, 32'h0);
    tick();
    chk("c1_vld",  {31'd0, ifu_vld}, 32'd0);
    chk("c1_insa", ins_a, 32'h4);
    tick(); head("s0", 32'h0);
    tick(); head("s4", 32'h4);
    tick(); head("s8", 32'h8);
    tick(); head("sC", 32'hC);

    // Stall for 10 cycles: queue fills to 4, fetching stops
    stall = 1'b1;
    tick(); head("st6", 32'hC);
    chk("st6_inse", {31'd0, ins_e}, 32'd1);
    chk("st6_insa", ins_a, 32'h18);
    for (int i = 7; i <= 14; i++) begin
      tick(); head("stall", 32'hC);
      chk("stall_inse", {31'd0, ins_e}, 32'd0);
      chk("stall_insa", ins_a, 32'h1C);
    end
    tick(); head("rel", 32'hC);
    stall = 1'b0; #1;
    chk("rel_inse", {31'd0, ins_e}, 32'd1);
    chk("rel_insa", ins_a, 32'h1C);
    for (int k = 1; k <= 5; k++) begin
      tick(); head("rel_seq", 32'hC + 32'(4 * k));
    end

    // Branch while 3 entries queued and 0x10 in flight
    rst = 1'b1; tick(); tick(); rst = 1'b0; #1;
    tick(); tick(); head("b2", 32'h0);
    tick(); head("b3", 32'h4);
    stall = 1'b1;
    tick(); tick(); head("b5", 32'h4);
    chk("b5_inse", {31'd0, ins_e}, 32'd0);
    branch = 1'b1; br_adr = 32'h0000_0102; #1;
    chk("br_inse", {31'd0, ins_e}, 32'd0);
    tick(); branch = 1'b0; stall = 1'b0; #1;
    chk("b6_vld",  {31'd0, ifu_vld}, 32'd0);
    chk("b6_insa", ins_a, 32'h100);
    chk("b6_inse", {31'd0, ins_e}, 32'd1);
    tick(); chk("b7_vld", {31'd0, ifu_vld}, 32'd0);
    tick(); head("b100", 32'h100);
    tick(); head("b104", 32'h104);
    tick(); head("b108", 32'h108);

    // Steady-state branch then flush with 0x20 in flight
    branch = 1'b1; br_adr = 32'h0000_001C; #1;
    chk("br2_inse", {31'd0, ins_e}, 32'd0);
    tick(); branch = 1'b0; #1;
    chk("d11_vld",  {31'd0, ifu_vld}, 32'd0);
    chk("d11_insa", ins_a, 32'h1C);
    tick(); chk("d12_vld", {31'd0, ifu_vld}, 32'd0);
    tick(); head("d1C", 32'h1C);
    flush = 1'b1; #1;
    chk("fl_inse", {31'd0, ins_e}, 32'd0);
    chk("fl_insa", ins_a, 32'h24);
    tick(); flush = 1'b0; #1;
    chk("f14_vld",  {31'd0, ifu_vld}, 32'd0);
    chk("f14_insa", ins_a, 32'h20);
    chk("f14_inse", {31'd0, ins_e}, 32'd1);
    tick(); chk("f15_vld", {31'd0, ifu_vld}, 32'd0);
    tick(); head("f20", 32'h20);
    tick(); head("f24", 32'h24);

    // Branch and flush together, then PC wrap
    branch = 1'b1; flush = 1'b1; br_adr = 32'h0000_0040;
    tick(); branch = 1'b0; flush = 1'b0; #1;
    chk("e18_vld",  {31'd0, ifu_vld}, 32'd0);
    chk("e18_insa", ins_a, 32'h40);
    tick(); tick(); head("e40", 32'h40);
    tick(); head("e44", 32'h44);
    branch = 1'b1; br_adr = 32'hFFFF_FFF8;
    tick(); branch = 1'b0; #1;
    chk("w_insa0", ins_a, 32'hFFFF_FFF8);
    tick(); chk("w_insa1", ins_a, 32'hFFFF_FFFC);
    tick(); chk("w_insa2", ins_a, 32'h0);
    head("wF8", 32'hFFFF_FFF8);
    tick(); head("wFC", 32'hFFFF_FFFC);
    tick(); head("w00", 32'h0);

    // Reset pulse with queue full
    stall = 1'b1;
    tick(); tick(); tick(); head("full", 32'h0);
    chk("full_inse", {31'd0, ins_e}, 32'd0);
    chk("full_insa", ins_a, 32'h10);
    rst = 1'b1; #1;
    chk("ar_vld",  {31'd0, ifu_vld}, 32'd0);
    chk("ar_pc",   ifu_pc, 32'd0);
    chk("ar_ins",  ifu_ins, 32'd0);
    chk("ar_inse", {31'd0, ins_e}, 32'd0);
    chk("ar_insa", ins_a, 32'd0);
    tick(); stall = 1'b0; rst = 1'b0; #1;
    chk("rr_inse", {31'd0, ins_e}, 32'd1);
    chk("rr_insa", ins_a, 32'h0);
    tick(); chk("rr1_vld", {31'd0, ifu_vld}, 32'd0);
    tick(); head("rr0", 32'h0);
    tick(); head("rr4", 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
